// File: rtl/dark_frame_judge_if.sv
// Pixel/count stream from the dark-pixel counter stage plus the per-frame judgement results.
interface dark_frame_judge_if;
  logic        iDVAL;
  logic [15:0] iDarkCounter;
  logic [15:0] iTHRESH_ON;
  logic [15:0] iTHRESH_OFF;
  logic [15:0] oFrameCount;
  logic        oFrameValid;
  logic        oDark;
  logic [15:0] oFrameNum;

  modport master (
    output iDVAL, iDarkCounter, iTHRESH_ON, iTHRESH_OFF,
    input  oFrameCount, oFrameValid, oDark, oFrameNum
  );

  modport slave (
    input  iDVAL, iDarkCounter, iTHRESH_ON, iTHRESH_OFF,
    output oFrameCount, oFrameValid, oDark, oFrameNum
  );
endinterface

// File: rtl/dark_frame_judge.sv
// Captures the final dark count of each frame and makes a debounced, hysteretic
// dark/light decision from it, evaluated once per completed frame.
module dark_frame_judge #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CONFIRM  = 3
) (
  input logic               iCLK,
  input logic               iRST,
  dark_frame_judge_if.slave bus
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);
  localparam logic [3:0]    CONFIRM_Q = 4'(CONFIRM);

  localparam logic [1:0] LIGHT      = 2'd0;
  localparam logic [1:0] PEND_DARK  = 2'd1;
  localparam logic [1:0] DARK       = 2'd2;
  localparam logic [1:0] PEND_LIGHT = 2'd3;

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [15:0]   last_cnt_r;
  logic [1:0]    state_r;
  logic [3:0]    q_r;
  logic [15:0]   frame_cnt_r;
  logic          frame_valid_r;
  logic          dark_r;
  logic [15:0]   frame_num_r;

  logic          final_s;
  logic          qualify_s;
  logic [3:0]    q_inc_s;
  logic [1:0]    state_nxt_s;
  logic [3:0]    q_nxt_s;

  assign final_s = bus.iDVAL && (x_r == X_LAST) && (y_r == Y_LAST);
  assign q_inc_s = q_r + 4'd1;

  // Qualification and next-state for the once-per-frame decision; last_cnt_r is the count being captured.
  always_comb begin
    state_nxt_s = state_r;
    q_nxt_s     = q_r;
    if ((state_r == LIGHT) || (state_r == PEND_DARK)) begin
      qualify_s = (last_cnt_r >= bus.iTHRESH_ON);
    end else begin
      qualify_s = (last_cnt_r <= bus.iTHRESH_OFF);
    end
    case (state_r)
      LIGHT, DARK: begin
        if (qualify_s) begin
          if (CONFIRM_Q == 4'd1) begin
            state_nxt_s = (state_r == LIGHT) ? DARK : LIGHT;
            q_nxt_s     = 4'd0;
          end else begin
            state_nxt_s = (state_r == LIGHT) ? PEND_DARK : PEND_LIGHT;
            q_nxt_s     = 4'd1;
          end
        end else begin
          q_nxt_s = 4'd0;
        end
      end
      PEND_DARK, PEND_LIGHT: begin
        if (!qualify_s) begin
          state_nxt_s = (state_r == PEND_DARK) ? LIGHT : DARK;
          q_nxt_s     = 4'd0;
        end else if (q_inc_s == CONFIRM_Q) begin
          state_nxt_s = (state_r == PEND_DARK) ? DARK : LIGHT;
          q_nxt_s     = 4'd0;
        end else begin
          q_nxt_s = q_inc_s;
        end
      end
      default: begin
        state_nxt_s = LIGHT;
        q_nxt_s     = 4'd0;
      end
    endcase
  end

  // Raster position tracking; only valid cycles advance it.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x_r <= '0;
      y_r <= '0;
    end else if (bus.iDVAL) begin
      if (x_r == X_LAST) begin
        x_r <= '0;
        y_r <= (y_r == Y_LAST) ? '0 : y_r + YW'(1);
      end else begin
        x_r <= x_r + XW'(1);
      end
    end else begin
      x_r <= x_r;
      y_r <= y_r;
    end
  end

  // Count capture and decision update. Upstream already cleared its count on
  // the final pixel, so the frame result is the value held from the pixel before.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      last_cnt_r    <= 16'd0;
      frame_cnt_r   <= 16'd0;
      frame_valid_r <= 1'b0;
      frame_num_r   <= 16'd0;
      state_r       <= LIGHT;
      q_r           <= 4'd0;
      dark_r        <= 1'b0;
    end else begin
      frame_valid_r <= final_s;
      if (final_s) begin
        last_cnt_r  <= 16'd0;
        frame_cnt_r <= last_cnt_r;
        frame_num_r <= frame_num_r + 16'd1;
        state_r     <= state_nxt_s;
        q_r         <= q_nxt_s;
        dark_r      <= (state_nxt_s == DARK) || (state_nxt_s == PEND_LIGHT);
      end else if (bus.iDVAL) begin
        last_cnt_r <= bus.iDarkCounter;
      end else begin
        last_cnt_r <= last_cnt_r;
      end
    end
  end

  assign bus.oFrameCount = frame_cnt_r;
  assign bus.oFrameValid = frame_valid_r;
  assign bus.oDark       = dark_r;
  assign bus.oFrameNum   = frame_num_r;

endmodule

// File: tb/tb_dark_frame_judge.sv
// Scoreboard bench for dark_frame_judge on a small 8x4 raster, plus a 1x1 instance for frame-number wrap.
module tb_dark_frame_judge;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int NPIX = H * V;
  localparam int CONF = 3;

  typedef struct packed {
    logic [15:0] cnt;
    logic        dark;
    logic [15:0] num;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  logic        dark_m;
  int          q_m;
  logic [15:0] fnum_m;

  dark_frame_judge_if bus ();
  dark_frame_judge_if bus2 ();

  dark_frame_judge #(.H_ACTIVE(H), .V_ACTIVE(V), .CONFIRM(CONF)) dut (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus)
  );

  dark_frame_judge #(.H_ACTIVE(1), .V_ACTIVE(1), .CONFIRM(CONF)) dut_wrap (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    dark_m = 1'b0;
    q_m    = 0;
    fnum_m = 16'd0;
  endtask

  task automatic model_frame(input logic [15:0] c);
    exp_t e;
    logic qual;
    qual = dark_m ? (c <= bus.iTHRESH_OFF) : (c >= bus.iTHRESH_ON);
    if (qual) begin
      q_m++;
      if (q_m == CONF) begin
        dark_m = ~dark_m;
        q_m    = 0;
      end
    end else begin
      q_m = 0;
    end
    fnum_m = fnum_m + 16'd1;
    e.cnt  = c;
    e.dark = dark_m;
    e.num  = fnum_m;
    sb_q.push_back(e);
  endtask

  function automatic logic [15:0] pix_val(input int p, input logic [15:0] c);
    if (p == NPIX - 1)      return 16'd0;
    else if (p >= NPIX - 2) return c;
    else                    return 16'((p * int'(c)) / (NPIX - 2));
  endfunction

  // Drives one frame whose captured count should be c; gap idle cycles between pixels.
  task automatic drive_frame(input logic [15:0] c, input int gap);
    for (int p = 0; p < NPIX; p++) begin
      @(posedge clk); #1;
      bus.iDVAL        = 1'b1;
      bus.iDarkCounter = pix_val(p, c);
      if (p == NPIX - 1) begin
        model_frame(c);
      end else if (gap > 0) begin
        @(posedge clk); #1;
        bus.iDVAL = 1'b0;
        repeat (gap - 1) @(posedge clk);
      end
    end
    @(posedge clk); #1;
    bus.iDVAL = 1'b0;
    @(negedge clk);
    check("pulse", {31'd0, bus.oFrameValid}, 32'd1);
    @(negedge clk);
    check("pulse_width", {31'd0, bus.oFrameValid}, 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    bus.iDVAL = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_count", {16'd0, bus.oFrameCount}, 32'd0);
    check("rst_valid", {31'd0, bus.oFrameValid}, 32'd0);
    check("rst_dark",  {31'd0, bus.oDark}, 32'd0);
    check("rst_num",   {16'd0, bus.oFrameNum}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: every frame pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.oFrameValid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {31'd0, bus.oFrameValid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("frame_count", {16'd0, bus.oFrameCount}, {16'd0, e.cnt});
        check("frame_dark",  {31'd0, bus.oDark}, {31'd0, e.dark});
        check("frame_num",   {16'd0, bus.oFrameNum}, {16'd0, e.num});
      end
    end
  end

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rst_n             = 1'b0;
    bus.iDVAL         = 1'b0;
    bus.iDarkCounter  = 16'd0;
    bus.iTHRESH_ON    = 16'd20;
    bus.iTHRESH_OFF   = 16'd5;
    bus2.iDVAL        = 1'b0;
    bus2.iDarkCounter = 16'd0;
    bus2.iTHRESH_ON   = 16'hFFFF;
    bus2.iTHRESH_OFF  = 16'd0;
    model_reset();
    repeat (2) @(posedge clk);
    apply_reset();

    // Ramp frame: captured value is the count at pixel 30.
    drive_frame(16'd30, 0);
    check("ramp_num", {16'd0, bus.oFrameNum}, 32'd1);
    check("ramp_cnt", {16'd0, bus.oFrameCount}, 32'd30);
    drive_frame(16'd30, 3);

    // Debounce into DARK.
    apply_reset();
    drive_frame(16'd25, 0);
    drive_frame(16'd25, 0);
    drive_frame(16'd10, 0);
    drive_frame(16'd25, 0);
    drive_frame(16'd25, 0);
    check("dark_before_6th", {31'd0, bus.oDark}, 32'd0);
    drive_frame(16'd25, 0);
    check("dark_after_6th", {31'd0, bus.oDark}, 32'd1);

    // Hysteresis band, then inclusive OFF threshold.
    drive_frame(16'd12, 0);
    drive_frame(16'd12, 0);
    drive_frame(16'd12, 0);
    check("dark_in_band", {31'd0, bus.oDark}, 32'd1);
    drive_frame(16'd3, 1);
    drive_frame(16'd4, 0);
    check("dark_before_off", {31'd0, bus.oDark}, 32'd1);
    drive_frame(16'd5, 0);
    check("dark_after_off", {31'd0, bus.oDark}, 32'd0);

    // Reset partway through frame 2 while pending dark.
    apply_reset();
    drive_frame(16'd25, 0);
    for (int p = 0; p < 17; p++) begin
      @(posedge clk); #1;
      bus.iDVAL        = 1'b1;
      bus.iDarkCounter = pix_val(p, 16'd25);
    end
    apply_reset();
    drive_frame(16'd25, 0);
    check("post_reset_num", {16'd0, bus.oFrameNum}, 32'd1);
    check("post_reset_dark", {31'd0, bus.oDark}, 32'd0);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    // Frame number wrap on the 1x1 instance: every valid is a final pixel.
    @(posedge clk); #1;
    bus2.iDVAL = 1'b1;
    @(negedge clk);
    repeat (65535) @(negedge clk);
    check("wrap_ffff", {16'd0, bus2.oFrameNum}, 32'h0000_FFFF);
    @(negedge clk);
    check("wrap_zero", {16'd0, bus2.oFrameNum}, 32'd0);
    check("wrap_pulse", {31'd0, bus2.oFrameValid}, 32'd1);
    @(posedge clk); #1;
    bus2.iDVAL = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
